alu_result_fifo: RTL

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_result_fifo.sv | 90 +++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding and the packed result record carried
// from the ALU into the result FIFO.
package alu_pkg;

  localparam int ALU_Y_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SLT = 3'b101,
    SLL = 3'b110,
    SRL = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e              sel;
    logic                 carry;
    logic                 zero;
    logic [ALU_Y_W-1:0]   y;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO between the ALU and its consumer: registered output, no bypass.
// Optional sticky carry/zero flags are built when ALU_RESULT_STICKY_EN is defined.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int Y_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Y_W-1:0]           in_y,
  input  logic                     in_zero,
  input  logic                     in_carry,
  input  logic [2:0]               in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Y_W-1:0]           out_y,
  output logic                     out_zero,
  output logic                     out_carry,
  output logic [2:0]               out_sel,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RESULT_STICKY_EN
  ,
  input  logic                     clr_sticky,
  output logic                     sticky_carry,
  output logic                     sticky_zero
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SEL_W = $bits(alu_op_e);
  localparam int ENT_W = SEL_W + 2 + Y_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;

  // in_ready looks only at occupancy, so a full FIFO never accepts a push
  // even when the consumer is popping in the same cycle.
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_sel, in_carry, in_zero, in_y};
  end

  assign head = mem[rptr];
  assign {out_sel, out_carry, out_zero, out_y} = out_valid ? head : '0;

`ifdef ALU_RESULT_STICKY_EN
  // A flag-raising push wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_carry <= 1'b0;
      sticky_zero  <= 1'b0;
    end else begin
      if (push && in_carry)  sticky_carry <= 1'b1;
      else if (clr_sticky)   sticky_carry <= 1'b0;
      if (push && in_zero)   sticky_zero  <= 1'b1;
      else if (clr_sticky)   sticky_zero  <= 1'b0;
    end
  end
`endif

endmodule
